// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer
// Description : Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer
//               with memory handshakes, write-enable gating, retirement count.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
    parameter int INSTRUCTION_SIZE = 32,
    parameter int COUNT_WIDTH      = 32,
    parameter int MEM_TIMEOUT      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [INSTRUCTION_SIZE-1:0] instruction,
    input  logic                        cu_rf_write_en,
    input  logic                        cu_dm_write_en,
    input  logic                        imem_ready,
    input  logic                        dmem_ready,
    output logic                        imem_req,
    output logic                        ir_load,
    output logic                        dmem_req,
    output logic                        rf_write_en,
    output logic                        dm_write_en,
    output logic                        pc_en,
    output logic                        busy,
    output logic                        halted,
    output logic                        illegal_instr,
    output logic                        mem_timeout,
    output logic [COUNT_WIDTH-1:0]      instr_count
);

    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] c_WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_ECALL  = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        K_ALU   = 2'd0,
        K_LOAD  = 2'd1,
        K_STORE = 2'd2
    } kind_e;

    state_e                 r_state;
    state_e                 w_next;
    kind_e                  r_kind;
    kind_e                  w_dec_kind;
    logic                   w_dec_ok;
    logic                   w_dec_ecall;
    logic [WW-1:0]          r_wait;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_illegal;
    logic                   r_timeout;
    logic                   w_retire;
    logic                   w_set_illegal;
    logic                   w_set_timeout;
    logic                   w_waiting;
    logic [6:0]             w_opcode;
    logic                   w_unused_instr_bits;

    assign w_opcode = instruction[6:0];
    // Only the opcode field steers the sequencer; the rest belongs to the datapath.
    assign w_unused_instr_bits = ^instruction[INSTRUCTION_SIZE-1:7];

    always_comb begin
        w_dec_kind  = K_ALU;
        w_dec_ok    = 1'b0;
        w_dec_ecall = 1'b0;
        case (w_opcode)
            c_OPC_LOAD:   begin w_dec_kind = K_LOAD;  w_dec_ok = 1'b1; end
            c_OPC_STORE:  begin w_dec_kind = K_STORE; w_dec_ok = 1'b1; end
            c_OPC_OP,
            c_OPC_OP_IMM: begin w_dec_kind = K_ALU;   w_dec_ok = 1'b1; end
            c_OPC_ECALL:  w_dec_ecall = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_kind    <= K_ALU;
            r_wait    <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_kind <= w_dec_kind;
            end
            // Any state change clears the wait counter, covering entry to FETCH/MEMORY.
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_waiting) begin
                r_wait <= r_wait + WW'(1);
            end
            if (w_retire) begin
                r_count <= r_count + COUNT_WIDTH'(1);
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        w_waiting     = 1'b0;
        imem_req      = 1'b0;
        ir_load       = 1'b0;
        dmem_req      = 1'b0;
        rf_write_en   = 1'b0;
        dm_write_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    w_next  = S_DECODE;
                end else if (r_wait == c_WAIT_LAST) begin
                    w_set_timeout = 1'b1;
                    w_next        = S_HALT;
                end else begin
                    w_waiting = 1'b1;
                end
            end
            S_DECODE: begin
                if (w_dec_ok) begin
                    w_next = S_EXECUTE;
                end else begin
                    w_set_illegal = ~w_dec_ecall;
                    w_next        = S_HALT;
                end
            end
            S_EXECUTE: begin
                w_next = (r_kind == K_ALU) ? S_WRITEBACK : S_MEMORY;
            end
            S_MEMORY: begin
                dmem_req    = 1'b1;
                dm_write_en = (r_kind == K_STORE) & cu_dm_write_en;
                if (dmem_ready) begin
                    if (r_kind == K_STORE) begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WRITEBACK;
                    end
                end else if (r_wait == c_WAIT_LAST) begin
                    w_set_timeout = 1'b1;
                    w_next        = S_HALT;
                end else begin
                    w_waiting = 1'b1;
                end
            end
            S_WRITEBACK: begin
                rf_write_en = cu_rf_write_en;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            default: w_next = S_HALT;
        endcase
        if (reset) begin
            imem_req    = 1'b0;
            ir_load     = 1'b0;
            dmem_req    = 1'b0;
            rf_write_en = 1'b0;
            dm_write_en = 1'b0;
            w_retire    = 1'b0;
        end
    end

    assign pc_en         = w_retire;
    assign busy          = ~reset & (r_state != S_IDLE) & (r_state != S_HALT);
    assign halted        = ~reset & (r_state == S_HALT);
    assign illegal_instr = ~reset & r_illegal;
    assign mem_timeout   = ~reset & r_timeout;
    assign instr_count   = reset ? '0 : r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_sequencer
// Description : Directed self-checking bench for multicycle_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] instruction;
    logic        cu_rf_write_en;
    logic        cu_dm_write_en;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_load;
    logic        dmem_req;
    logic        rf_write_en;
    logic        dm_write_en;
    logic        pc_en;
    logic        busy;
    logic        halted;
    logic        illegal_instr;
    logic        mem_timeout;
    logic [3:0]  instr_count;
    logic [9:0]  obs;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_sequencer #(
        .INSTRUCTION_SIZE(32),
        .COUNT_WIDTH     (4),
        .MEM_TIMEOUT     (16)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .instruction   (instruction),
        .cu_rf_write_en(cu_rf_write_en),
        .cu_dm_write_en(cu_dm_write_en),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .imem_req      (imem_req),
        .ir_load       (ir_load),
        .dmem_req      (dmem_req),
        .rf_write_en   (rf_write_en),
        .dm_write_en   (dm_write_en),
        .pc_en         (pc_en),
        .busy          (busy),
        .halted        (halted),
        .illegal_instr (illegal_instr),
        .mem_timeout   (mem_timeout),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    // {imem_req, ir_load, dmem_req, rf_we, dm_we, pc_en, busy, halted, illegal, timeout}
    assign obs = {imem_req, ir_load, dmem_req, rf_write_en, dm_write_en,
                  pc_en, busy, halted, illegal_instr, mem_timeout};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        cu_rf_write_en = 1'b1; cu_dm_write_en = 1'b1; instruction = 32'h00730333;
        tick();
        tick();
        n_cmp++;
        if (obs !== 10'b0) begin
            n_err++; $display("FAIL reset_outputs got=%b want=%b", obs, 10'b0);
        end
        n_cmp++;
        if (instr_count !== 4'd0) begin
            n_err++; $display("FAIL reset_count got=%0d want=0", instr_count);
        end
        start = 1'b0;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 10'b0) begin
            n_err++; $display("FAIL reset_idle got=%b want=%b", obs, 10'b0);
        end
    endtask

    task automatic test_op();
        logic [9:0] exp_v [0:5];
        exp_v = '{10'b0000000000, 10'b1100001000, 10'b0000001000,
                  10'b0000001000, 10'b0001011000, 10'b1100001000};
        do_reset();
        instruction = 32'h00730333; start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        cu_rf_write_en = 1'b1; cu_dm_write_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp++;
            if (obs !== exp_v[i]) begin
                n_err++; $display("FAIL op_cycle%0d got=%b want=%b", i, obs, exp_v[i]);
            end
            n_cmp++;
            if (instr_count !== ((i == 5) ? 4'd1 : 4'd0)) begin
                n_err++; $display("FAIL op_count%0d got=%0d", i, instr_count);
            end
            tick();
        end
    endtask

    task automatic test_load();
        logic [9:0] exp_v [0:9];
        exp_v = '{10'b0000000000, 10'b1100001000, 10'b0000001000, 10'b0000001000,
                  10'b0010001000, 10'b0010001000, 10'b0010001000, 10'b0010001000,
                  10'b0001011000, 10'b1100001000};
        do_reset();
        instruction = 32'h06B38183; start = 1'b1; imem_ready = 1'b1;
        cu_rf_write_en = 1'b1; cu_dm_write_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dmem_ready = (i == 7);
            #1;
            n_cmp++;
            if (obs !== exp_v[i]) begin
                n_err++; $display("FAIL load_cycle%0d got=%b want=%b", i, obs, exp_v[i]);
            end
            tick();
        end
        n_cmp++;
        if (instr_count !== 4'd1) begin
            n_err++; $display("FAIL load_count got=%0d want=1", instr_count);
        end
    endtask

    task automatic test_store();
        logic [9:0] exp_v [0:5];
        exp_v = '{10'b0000000000, 10'b1100001000, 10'b0000001000,
                  10'b0000001000, 10'b0010111000, 10'b1100001000};
        do_reset();
        instruction = 32'hB67381A3; start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        cu_rf_write_en = 1'b1; cu_dm_write_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp++;
            if (obs !== exp_v[i]) begin
                n_err++; $display("FAIL store_cycle%0d got=%b want=%b", i, obs, exp_v[i]);
            end
            tick();
        end
        n_cmp++;
        if (instr_count !== 4'd1) begin
            n_err++; $display("FAIL store_count got=%0d want=1", instr_count);
        end
    endtask

    task automatic test_halt();
        logic [31:0] instr_v [0:1];
        logic [9:0]  halt_v  [0:1];
        instr_v = '{32'h0000007F, 32'h00000073};
        halt_v  = '{10'b0000000110, 10'b0000000100};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            instruction = instr_v[k]; start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
            cu_rf_write_en = 1'b1; cu_dm_write_en = 1'b1;
            tick(); tick(); tick();
            start = 1'b0;
            #1;
            n_cmp++;
            if (obs !== halt_v[k]) begin
                n_err++; $display("FAIL halt%0d_state got=%b want=%b", k, obs, halt_v[k]);
            end
            start = 1'b1;
            tick(); tick();
            n_cmp++;
            if (obs !== halt_v[k]) begin
                n_err++; $display("FAIL halt%0d_start_ignored got=%b want=%b", k, obs, halt_v[k]);
            end
            n_cmp++;
            if (instr_count !== 4'd0) begin
                n_err++; $display("FAIL halt%0d_count got=%0d want=0", k, instr_count);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        instruction = 32'h00730333; start = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b1;
        cu_rf_write_en = 1'b1; cu_dm_write_en = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_cmp++;
            if (obs !== 10'b1000001000) begin
                n_err++; $display("FAIL timeout_wait%0d got=%b want=%b", i, obs, 10'b1000001000);
            end
            tick();
        end
        n_cmp++;
        if (obs !== 10'b0000000101) begin
            n_err++; $display("FAIL timeout_halt got=%b want=%b", obs, 10'b0000000101);
        end

        do_reset();
        start = 1'b1; imem_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        imem_ready = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 10'b1100001000) begin
            n_err++; $display("FAIL timeout_last_ready got=%b want=%b", obs, 10'b1100001000);
        end
        tick();
        n_cmp++;
        if (obs !== 10'b0000001000) begin
            n_err++; $display("FAIL timeout_decode got=%b want=%b", obs, 10'b0000001000);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        instruction = 32'hB67381A3; start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        cu_rf_write_en = 1'b1; cu_dm_write_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        #1;
        n_cmp++;
        if (obs !== 10'b0010101000 || instr_count !== 4'd1) begin
            n_err++; $display("FAIL mid_memory got=%b/%0d want=%b/1", obs, instr_count, 10'b0010101000);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 10'b0 || instr_count !== 4'd0) begin
            n_err++; $display("FAIL mid_reset_force got=%b/%0d want=0/0", obs, instr_count);
        end
        tick();
        reset = 1'b0; start = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 10'b0 || instr_count !== 4'd0) begin
            n_err++; $display("FAIL mid_reset_idle got=%b/%0d want=0/0", obs, instr_count);
        end
    endtask

    task automatic test_wrap();
        int pulses;
        pulses = 0;
        do_reset();
        instruction = 32'h00730333; start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        cu_rf_write_en = 1'b1; cu_dm_write_en = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (pc_en === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 16) begin
            n_err++; $display("FAIL wrap_pulses got=%0d want=16", pulses);
        end
        n_cmp++;
        if (instr_count !== 4'd15) begin
            n_err++; $display("FAIL wrap_before got=%0d want=15", instr_count);
        end
        tick();
        n_cmp++;
        if (instr_count !== 4'd0) begin
            n_err++; $display("FAIL wrap_after got=%0d want=0", instr_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; instruction = '0;
        cu_rf_write_en = 1'b0; cu_dm_write_en = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        test_reset();
        test_op();
        test_load();
        test_store();
        test_halt();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
